// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map and a
// highest-set-bit helper used on both the eligible and in-service vectors.
package irq_pkg;

  localparam int NSRC = 8;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_ENA   = 3'd1;
  localparam logic [2:0] REG_MODE  = 3'd2;
  localparam logic [2:0] REG_POL   = 3'd3;
  localparam logic [2:0] REG_SWSET = 3'd4;
  localparam logic [2:0] REG_ACK   = 3'd5;
  localparam logic [2:0] REG_EOI   = 3'd6;
  localparam logic [2:0] REG_INSVC = 3'd7;

  // Returns {valid, index} of the highest set bit; later iterations win.
  function automatic logic [3:0] hi_bit8(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per source with polarity correction and
// rising-edge detect on the corrected signal.
module irq_sync_edge
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] pol,
  output logic [NSRC-1:0] s,
  output logic [NSRC-1:0] edge_evt
);

  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;
  logic [NSRC-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      prev  <= s;
    end
  end

  // A POL write flips s immediately, which can look like an edge.
  assign s        = sync2 ^ pol;
  assign edge_evt = s & ~prev;

endmodule

// File: rtl/irq_controller.sv
// J1 interrupt controller: pending/enable/mode/polarity registers on the IO
// bus, nested in-service tracking and a registered request vector to the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  input  logic [15:0] io_addr,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic [7:0]  int_rqst,
  output logic        sel
);

  logic [NSRC-1:0] pend, ena, mode, pol, insvc;
  logic [NSRC-1:0] s, edge_evt;
  logic [NSRC-1:0] above, elig, w1c, swset, ack_onehot, ack_clr;
  logic [NSRC-1:0] pend_nxt, insvc_acked, insvc_nxt;
  logic [3:0]      insvc_hi, elig_hi, eoi_hi;
  logic [2:0]      idx;
  logic            wr_hit, rd_hit, ack, eoi;
  logic            unused_bits;

  irq_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .pol      (pol),
    .s        (s),
    .edge_evt (edge_evt)
  );

  assign sel         = (io_addr[15:4] == BASE[15:4]);
  assign idx         = io_addr[3:1];
  assign wr_hit      = io_wr & sel;
  assign rd_hit      = io_rd & sel;
  assign unused_bits = ^{io_addr[0], io_wdata[15:8]};

  assign insvc_hi = hi_bit8(insvc);
  assign above    = insvc_hi[3] ? (8'hFE << insvc_hi[2:0]) : 8'hFF;
  assign elig     = pend & ena & above;
  assign elig_hi  = hi_bit8(elig);

  assign ack        = rd_hit && (idx == REG_ACK) && elig_hi[3];
  assign eoi        = wr_hit && (idx == REG_EOI);
  assign ack_onehot = ack ? (8'd1 << elig_hi[2:0]) : 8'd0;
  assign ack_clr    = ack_onehot & mode;
  assign w1c        = (wr_hit && idx == REG_PEND)  ? io_wdata[7:0] : 8'd0;
  assign swset      = (wr_hit && idx == REG_SWSET) ? io_wdata[7:0] : 8'd0;

  // Edge bits: sets beat W1C, but an ACK clear beats everything.
  assign pend_nxt = (mode & (((pend & ~w1c) | edge_evt | swset) & ~ack_clr))
                  | (~mode & s);

  assign insvc_acked = insvc | ack_onehot;
  assign eoi_hi      = hi_bit8(insvc_acked);

  always_comb begin
    insvc_nxt = insvc_acked;
    if (eoi && eoi_hi[3]) insvc_nxt[eoi_hi[2:0]] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      ena      <= '0;
      mode     <= '0;
      pol      <= '0;
      insvc    <= '0;
      int_rqst <= '0;
    end else begin
      pend     <= pend_nxt;
      insvc    <= insvc_nxt;
      int_rqst <= elig;
      if (wr_hit && idx == REG_ENA)  ena  <= io_wdata[7:0];
      if (wr_hit && idx == REG_MODE) mode <= io_wdata[7:0];
      if (wr_hit && idx == REG_POL)  pol  <= io_wdata[7:0];
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (sel) begin
      case (idx)
        REG_PEND:  io_rdata = {8'h00, pend};
        REG_ENA:   io_rdata = {8'h00, ena};
        REG_MODE:  io_rdata = {8'h00, mode};
        REG_POL:   io_rdata = {8'h00, pol};
        REG_ACK:   io_rdata = {elig_hi[3], 12'h000, elig_hi[2:0]};
        REG_INSVC: io_rdata = {8'h00, insvc};
        default:   io_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario-driven bench for irq_controller; expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [2:0] R_PEND = 3'd0, R_ENA = 3'd1, R_MODE = 3'd2, R_POL = 3'd3,
                         R_SWSET = 3'd4, R_ACK = 3'd5, R_EOI = 3'd6, R_INSVC = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [15:0] io_addr;
  logic        io_wr, io_rd;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic [7:0]  int_rqst;
  logic        sel;

  logic [15:0] exp_q[$];
  logic [15:0] d, e;
  int          n_cmp = 0;
  int          n_err = 0;

  irq_controller #(.BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .io_addr  (io_addr),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .int_rqst (int_rqst),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  // All helpers start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] v);
    io_addr  = BASE | {12'h000, r, 1'b0};
    io_wdata = v;
    io_wr    = 1'b1;
    @(posedge clk);
    #1;
    io_wr   = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] r, output logic [15:0] v);
    io_addr = BASE | {12'h000, r, 1'b0};
    io_rd   = 1'b1;
    #4;
    v = io_rdata;
    @(posedge clk);
    #1;
    io_rd   = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== e) begin n_err++; $display("FAIL reset_reg%0d got %h exp %h", i, d, e); end
    end
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL reset_int_rqst got %h exp %h", int_rqst, e); end
    // Edge-mode pulse with nothing enabled: pend latches, no request.
    wr(R_MODE, 16'h00FF);
    irq_in[3] = 1'b1;
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0000);
    cyc(2);
    irq_in[3] = 1'b0;
    cyc(4);
    rd(R_PEND, d);
    e = exp_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL disabled_pend got %h exp %h", d, e); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL disabled_int_rqst got %h exp %h", int_rqst, e); end
    wr(R_PEND, 16'h00FF);
  endtask

  task automatic test_edge;
    wr(R_ENA, 16'h0008);
    irq_in[3] = 1'b1;
    exp_q.push_back(16'h0000);   // pend still clear 2 clocks in
    exp_q.push_back(16'h0000);   // int_rqst after 3 clocks
    exp_q.push_back(16'h0008);   // int_rqst after 4 clocks
    exp_q.push_back(16'h0008);   // pend
    exp_q.push_back(16'h8003);   // ack
    exp_q.push_back(16'h0008);   // insvc
    exp_q.push_back(16'h0000);   // pend after ack
    exp_q.push_back(16'h0000);   // int_rqst after ack
    cyc(2);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_pend_early got %h exp %h", d, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL edge_rqst_early got %h exp %h", int_rqst, e); end
    cyc(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL edge_rqst got %h exp %h", int_rqst, e); end
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_pend got %h exp %h", d, e); end
    rd(R_ACK, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_ack got %h exp %h", d, e); end
    rd(R_INSVC, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_insvc got %h exp %h", d, e); end
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_pend_after_ack got %h exp %h", d, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL edge_rqst_after_ack got %h exp %h", int_rqst, e); end
  endtask

  task automatic test_nesting;
    wr(R_ENA, 16'h00FF);
    irq_in[5] = 1'b1;
    irq_in[1] = 1'b1;
    exp_q.push_back(16'h0020);
    exp_q.push_back(16'h8005);
    exp_q.push_back(16'h0028);
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    cyc(5);
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL nest_rqst got %h exp %h", int_rqst, e); end
    rd(R_ACK, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL nest_ack got %h exp %h", d, e); end
    rd(R_INSVC, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL nest_insvc got %h exp %h", d, e); end
    wr(R_EOI, 16'hFFFF);
    rd(R_INSVC, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL nest_eoi1 got %h exp %h", d, e); end
    wr(R_EOI, 16'h0000);
    rd(R_INSVC, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL nest_eoi2 got %h exp %h", d, e); end
    cyc(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL nest_rqst_low got %h exp %h", int_rqst, e); end
    irq_in = 8'h00;
    wr(R_ENA, 16'h0000);
    wr(R_PEND, 16'h00FF);
    cyc(3);
  endtask

  task automatic test_level;
    wr(R_MODE, 16'h0000);
    wr(R_ENA, 16'h0001);
    irq_in[0] = 1'b1;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    cyc(3);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_pend got %h exp %h", d, e); end
    wr(R_PEND, 16'h0001);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_w1c got %h exp %h", d, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL level_rqst got %h exp %h", int_rqst, e); end
    irq_in[0] = 1'b0;
    cyc(2);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_release_early got %h exp %h", d, e); end
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_release got %h exp %h", d, e); end
  endtask

  task automatic test_collision;
    wr(R_MODE, 16'h00FF);
    wr(R_ENA, 16'h0000);
    irq_in[2] = 1'b1;
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0084);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    cyc(2);
    wr(R_PEND, 16'h0004);   // lands on the same edge as the event
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL collide_pend got %h exp %h", d, e); end
    wr(R_SWSET, 16'h0080);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL swset_pend got %h exp %h", d, e); end
    rd(R_ACK, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL ack_disabled got %h exp %h", d, e); end
    rd(R_INSVC, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL ack_disabled_insvc got %h exp %h", d, e); end
    irq_in = 8'h00;
    wr(R_PEND, 16'h00FF);
  endtask

  task automatic test_polarity;
    wr(R_MODE, 16'h0010);
    wr(R_POL, 16'h0010);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0010);
    cyc(2);
    wr(R_PEND, 16'h0010);   // drop the spurious event from the POL write
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL pol_spurious_clr got %h exp %h", d, e); end
    irq_in[4] = 1'b1;
    cyc(4);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL pol_rise got %h exp %h", d, e); end
    irq_in[4] = 1'b0;
    cyc(4);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL pol_fall got %h exp %h", d, e); end
  endtask

  task automatic test_decode;
    wr(R_ENA, 16'h0010);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    io_addr = 16'h0043;       // ENA with address bit 0 set
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (io_rdata !== e) begin n_err++; $display("FAIL decode_a0 got %h exp %h", io_rdata, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({15'h0, sel} !== e) begin n_err++; $display("FAIL decode_sel_hit got %h exp %h", sel, e); end
    io_addr = 16'h0052;
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (io_rdata !== e) begin n_err++; $display("FAIL decode_miss_data got %h exp %h", io_rdata, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({15'h0, sel} !== e) begin n_err++; $display("FAIL decode_sel_miss got %h exp %h", sel, e); end
    io_addr = 16'h0000;
    cyc(1);
  endtask

  task automatic test_async_reset;
    exp_q.push_back(16'h8004);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    rd(R_ACK, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_setup_ack got %h exp %h", d, e); end
    wr(R_SWSET, 16'h0010);
    rd(R_PEND, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_setup_pend got %h exp %h", d, e); end
    #2;
    reset = 1'b1;
    io_addr = BASE | {12'h000, R_PEND, 1'b0};
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (io_rdata !== e) begin n_err++; $display("FAIL rst_async_pend got %h exp %h", io_rdata, e); end
    io_addr = BASE | {12'h000, R_INSVC, 1'b0};
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (io_rdata !== e) begin n_err++; $display("FAIL rst_async_insvc got %h exp %h", io_rdata, e); end
    e = exp_q.pop_front(); n_cmp++;
    if ({8'h00, int_rqst} !== e) begin n_err++; $display("FAIL rst_async_rqst got %h exp %h", int_rqst, e); end
    io_addr = 16'h0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1);
    rd(R_ENA, d);
    e = exp_q.pop_front(); n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_async_ena got %h exp %h", d, e); end
  endtask

  initial begin
    reset    = 1'b1;
    irq_in   = 8'h00;
    io_addr  = 16'h0000;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    io_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1);
    test_reset();
    test_edge();
    test_nesting();
    test_level();
    test_collision();
    test_polarity();
    test_decode();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
